button_conditioner: RTL

- Front-end stage for the stopwatch start/stop/reset push-buttons.
- Synchronises raw asynchronous button inputs to clk and debounces each one independently.
- Produces a clean level, a single-cycle press pulse and a single-cycle release pulse per button.
- The stopwatch control logic consumes the press pulses directly and needs no edge detection of its own.

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_debounce_ch.sv | 155 +++++++++++++++
 rtl/button_conditioner.sv | 34 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for the stopwatch button front end.
package button_pkg;

    localparam int CLK_HZ           = 50_000_000;
    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_HOLD_CYC     = 50_000_000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // The debounced level is high for the whole accepted-press interval,
    // including the window where a release is still being qualified.
    function automatic logic state_is_down(input btn_state_t s);
        return (s == HELD) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered pulses.
// Optional long-press detection is compiled in with BTN_HOLD_EN.
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released,
    output logic hold
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC < 2 || HOLD_CYC <= DEBOUNCE_CYC) begin : g_param_check
        $error("button_debounce_ch: need DEBOUNCE_CYC >= 2 and HOLD_CYC > DEBOUNCE_CYC");
    end

    logic       sync1_q, sync2_q;
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Next-state and pulse decode for the debounce FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = state_is_down(state_d);
    end

    // Synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level    = level_q;
    assign pressed  = press_q;
    assign released = release_q;

`ifdef BTN_HOLD_EN
    localparam int HW = $clog2(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_done_q, hold_done_d;
    logic          hold_q, hold_d;

    // Hold timer restarts only on a fresh accepted press; a release bounce
    // back into HELD keeps the elapsed time.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        hold_done_d = hold_done_q;
        hold_d      = 1'b0;
        if (state_q == PRESS_WAIT && state_d == HELD) begin
            hold_cnt_d  = '0;
            hold_done_d = 1'b0;
        end else if (state_q == HELD && sync2_q) begin
            if (hold_cnt_q == HOLD_MAX) begin
                hold_d      = !hold_done_q;
                hold_done_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= hold_done_d;
            hold_q      <= hold_d;
        end
    end

    assign hold = hold_q;
`else
    assign hold = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch push-button front end: N_BTN independent debounced channels.
// Define BTN_HOLD_EN to enable the long-press btn_hold pulse.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN        = 3,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw      (btn_raw[i]),
            .level    (btn_level[i]),
            .pressed  (btn_press[i]),
            .released (btn_release[i]),
            .hold     (btn_hold[i])
        );
    end

endmodule
